// File: rtl/axi4_stream_pkg.sv
// Shared constants for the AXI4-Stream destination extractor: FSM state
// encodings, default widths, reset token value and debug-bus field positions.
package axi4_stream_pkg;

  localparam int DEST_WIDTH_DEFAULT = 2;
  localparam int DATA_WIDTH_DEFAULT = 64;

  typedef logic [1:0] state_t;

  localparam state_t STATE_IDLE = 2'd0;
  localparam state_t STATE_DEST = 2'd1;
  localparam state_t STATE_XFER = 2'd2;

  // Wide enough for any supported TDEST width; the top slices it down.
  localparam logic [31:0] TDEST_RESET_ALL = '1;

  localparam int DBG_STATE_LSB    = 0;
  localparam int DBG_BEAT_LSB     = 16;
  localparam int DBG_HS_LSB       = 32;
  localparam int DBG_MISMATCH_LSB = 80;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axi4_stream_dest_check.sv
// TDEST consistency checker: flags beats whose TDEST differs from the packet's
// token, with a sticky error flag and a saturating mismatch counter.
module axi4_stream_dest_check
  import axi4_stream_pkg::*;
#(
  parameter int C_AXIS_DEST_WIDTH = DEST_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         check,
  input  logic [C_AXIS_DEST_WIDTH-1:0] s_dest,
  input  logic [C_AXIS_DEST_WIDTH-1:0] tdest,
  output logic                         dest_err,
  output logic [15:0]                  mismatch_count
);

  logic mismatch;

  assign mismatch = check && (s_dest != tdest);

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_err       <= 1'b0;
      mismatch_count <= '0;
    end else if (mismatch) begin
      dest_err       <= 1'b1;
      mismatch_count <= sat_inc16(mismatch_count);
    end
  end

endmodule

// File: rtl/axi4_stream_dest_extractor.sv
// Splits a TDEST-tagged AXI4-Stream into a one-word destination token followed
// by the untagged packet. Optional TDEST checker under AXI4_STREAM_DEST_CHECK_EN.
module axi4_stream_dest_extractor
  import axi4_stream_pkg::*;
#(
  parameter int C_AXIS_DEST_WIDTH = DEST_WIDTH_DEFAULT,
  parameter int C_AXIS_DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         S_AXIS_TVALID,
  output logic                         S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                         S_AXIS_TLAST,
  input  logic [C_AXIS_DEST_WIDTH-1:0] S_AXIS_TDEST,
  output logic                         M_AXIS_DEST_TVALID,
  input  logic                         M_AXIS_DEST_TREADY,
  output logic [C_AXIS_DEST_WIDTH-1:0] M_AXIS_DEST_TDATA,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                         M_AXIS_TLAST,
  output logic [31:0]                  pkt_count,
  output logic                         dest_err,
  output logic [127:0]                 debug
);

  localparam logic [C_AXIS_DEST_WIDTH-1:0] TDEST_RESET = TDEST_RESET_ALL[C_AXIS_DEST_WIDTH-1:0];

  state_t                         state;
  state_t                         state_next;
  logic [C_AXIS_DEST_WIDTH-1:0]   tdest;
  logic [15:0]                    beat_count;
  logic [15:0]                    mismatch_count;
  logic                           dest_hs;
  logic                           beat_hs;
  logic                           last_hs;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= STATE_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = STATE_IDLE;
    case (state)
      STATE_IDLE: state_next = S_AXIS_TVALID ? STATE_DEST : STATE_IDLE;
      STATE_DEST: state_next = dest_hs ? STATE_XFER : STATE_DEST;
      STATE_XFER: state_next = last_hs ? STATE_IDLE : STATE_XFER;
      default:    state_next = STATE_IDLE;
    endcase
  end

  // Handshakes are masked during reset so no beat is lost or double-counted
  // while the context is being dropped.
  always_comb begin
    S_AXIS_TREADY      = 1'b0;
    M_AXIS_TVALID      = 1'b0;
    M_AXIS_DEST_TVALID = 1'b0;
    if (!rst) begin
      case (state)
        STATE_DEST: M_AXIS_DEST_TVALID = 1'b1;
        STATE_XFER: begin
          M_AXIS_TVALID = S_AXIS_TVALID;
          S_AXIS_TREADY = M_AXIS_TREADY;
        end
        default: ;
      endcase
    end
  end

  assign dest_hs      = M_AXIS_DEST_TVALID & M_AXIS_DEST_TREADY;
  assign beat_hs      = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_hs      = beat_hs & S_AXIS_TLAST;
  assign M_AXIS_TDATA = S_AXIS_TDATA;
  assign M_AXIS_TLAST = S_AXIS_TLAST;
  assign M_AXIS_DEST_TDATA = tdest;

  always_ff @(posedge clk) begin
    if (rst) begin
      tdest      <= TDEST_RESET;
      beat_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (state == STATE_IDLE && S_AXIS_TVALID) tdest <= S_AXIS_TDEST;
      if (last_hs) begin
        beat_count <= '0;
        pkt_count  <= pkt_count + 32'd1;
      end else if (beat_hs) begin
        beat_count <= sat_inc16(beat_count);
      end
    end
  end

`ifdef AXI4_STREAM_DEST_CHECK_EN
  axi4_stream_dest_check #(
    .C_AXIS_DEST_WIDTH(C_AXIS_DEST_WIDTH)
  ) u_dest_check (
    .clk           (clk),
    .rst           (rst),
    .check         (beat_hs),
    .s_dest        (S_AXIS_TDEST),
    .tdest         (tdest),
    .dest_err      (dest_err),
    .mismatch_count(mismatch_count)
  );
`else
  assign dest_err       = 1'b0;
  assign mismatch_count = '0;
`endif

  always_comb begin
    debug = '0;
    debug[DBG_STATE_LSB +: 2]     = state;
    debug[DBG_BEAT_LSB +: 16]     = beat_count;
    debug[DBG_HS_LSB +: 3]        = {last_hs, beat_hs, dest_hs};
    debug[DBG_MISMATCH_LSB +: 16] = mismatch_count;
  end

endmodule

// File: doc/axi4_stream_dest_extractor.md
# axi4_stream_dest_extractor

Inverse of the TDEST tagger in the accelerator stream path: accepts a packetized AXI4-Stream carrying TDEST and splits it into a one-word destination token stream and an untagged data stream. The block sits on the return side of the accelerator fabric, where routed packets are handed back to a consumer that expects the destination as a separate token ahead of each packet. It handles one packet at a time, with a registered destination token and a pass-through data path.

## Interface
Parameters:
- C_AXIS_DEST_WIDTH, 2, width of TDEST and of the destination token
- C_AXIS_DATA_WIDTH, 64, data width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous active-high reset
- S_AXIS_TVALID  in  1  input stream valid
- S_AXIS_TREADY  out  1  input stream ready
- S_AXIS_TDATA  in  C_AXIS_DATA_WIDTH  input data
- S_AXIS_TLAST  in  1  last beat of packet
- S_AXIS_TDEST  in  C_AXIS_DEST_WIDTH  packet destination
- M_AXIS_DEST_TVALID  out  1  destination token valid
- M_AXIS_DEST_TREADY  in  1  destination token ready
- M_AXIS_DEST_TDATA  out  C_AXIS_DEST_WIDTH  destination token
- M_AXIS_TVALID  out  1  output data valid
- M_AXIS_TREADY  in  1  output data ready
- M_AXIS_TDATA  out  C_AXIS_DATA_WIDTH  output data (= S_AXIS_TDATA)
- M_AXIS_TLAST  out  1  output last (= S_AXIS_TLAST)
- pkt_count  out  32  packets completed since reset, wraps
- dest_err  out  1  sticky TDEST-mismatch flag (see Configuration)
- debug  out  128  state, beat count, handshakes; unused bits 0

## Operation
- States: STATE_IDLE(0), STATE_DEST(1), STATE_XFER(2); other encodings go to STATE_IDLE.
- STATE_IDLE: S_AXIS_TREADY=0. If S_AXIS_TVALID=1, latch S_AXIS_TDEST into tdest and go to STATE_DEST. No input beat is consumed.
- STATE_DEST: M_AXIS_DEST_TVALID=1, M_AXIS_DEST_TDATA=tdest, S_AXIS_TREADY=0. On M_AXIS_DEST_TREADY, go to STATE_XFER.
- STATE_XFER:
  - M_AXIS_TVALID = S_AXIS_TVALID.
  - S_AXIS_TREADY = M_AXIS_TREADY.
  - On a beat handshake (S_AXIS_TVALID & M_AXIS_TREADY), increment the beat counter (16 bit, saturates at 0xFFFF).
  - If that beat also has TLAST: increment pkt_count, clear the beat counter, go to STATE_IDLE.
  - State changes only on a completed handshake; TVALID&TLAST without ready does not end the packet.
- Outside STATE_XFER, M_AXIS_TVALID=0. Outside STATE_DEST, M_AXIS_DEST_TVALID=0.
- M_AXIS_DEST_TDATA is registered and holds tdest at all times.

## Timing
- Reset values:
  - state=STATE_IDLE
  - tdest = all ones
  - pkt_count=0, beat counter=0, dest_err=0
  - all TVALID/TREADY outputs 0
- First beat valid at cycle 0 (IDLE) -> token valid at cycle 1.
  - If the token is accepted at cycle 1, the first data beat is presentable at cycle 2.
- Single-beat packet: IDLE, DEST, XFER (1 beat), IDLE.
- Back-to-back packets: next packet's token is valid at the earliest 2 cycles after the previous TLAST handshake; minimum 2-cycle bubble on the input.
- Token backpressure holds STATE_DEST indefinitely; no input is consumed while in STATE_DEST.
- Reset mid-packet: returns to STATE_IDLE and drops context. Remaining beats of that packet are treated as a new packet, and a fresh token is generated from their TDEST.
- pkt_count wraps from 0xFFFFFFFF to 0.

## Configuration
- Macro: AXI4_STREAM_DEST_CHECK_EN.
- Defined:
  - every STATE_XFER handshake compares S_AXIS_TDEST with tdest;
  - on a mismatch, dest_err sets, stays set until rst, and debug[95:80] counts mismatched beats (saturating);
  - mismatched beats are still forwarded unchanged.
- Undefined: dest_err tied 0, no comparator, debug[95:80]=0.

## Structure
- Shared package axi4_stream_pkg:
  - state localparams STATE_IDLE/STATE_DEST/STATE_XFER;
  - default width constants;
  - reset tdest value (all ones).
- One sub-module is natural: axi4_stream_dest_check (comparator, sticky flag, mismatch counter), instantiated only under AXI4_STREAM_DEST_CHECK_EN.

## Test plan
- Packet of 4 beats, TDEST=2, sinks always ready:
  - token 2 at cycle 1;
  - data beats on cycles 2-5 with TLAST on beat 4;
  - pkt_count=1.
- M_AXIS_DEST_TREADY held low 5 cycles:
  - token stays valid with value 1;
  - S_AXIS_TREADY=0 throughout;
  - data starts the cycle after token acceptance.
- M_AXIS_TREADY toggles every cycle during an 8-beat packet:
  - exactly 8 beats forwarded in order, data identical;
  - the TLAST beat stalled once without ready does not end the packet.
- Two back-to-back single-beat packets, TDEST=0 then 3:
  - tokens 0, 3;
  - 2-cycle bubble;
  - pkt_count=2.
- rst asserted after beat 2 of a 5-beat packet, TDEST=1:
  - outputs return to reset values;
  - the remaining 3 beats produce new token 1 and a 3-beat packet.
- With AXI4_STREAM_DEST_CHECK_EN, TDEST changes 1->2 on beat 3 of 4:
  - dest_err=1 from the next cycle;
  - mismatch count=2;
  - all 4 beats forwarded;
  - without the macro, dest_err stays 0.
